// File: rtl/th_flt_pkg.sv
// Shared types for the threshold-filter nibble port: FSM states and the
// {threshold, Higher} select codes that both sequencer and filter decode.
package th_flt_pkg;

  typedef enum logic [2:0] {IDLE, S_LO, S_HI, T_LO, T_HI} state_e;

  localparam logic [1:0] NSEL_S_LO = 2'b00;
  localparam logic [1:0] NSEL_S_HI = 2'b01;
  localparam logic [1:0] NSEL_T_LO = 2'b10;
  localparam logic [1:0] NSEL_T_HI = 2'b11;

  // {threshold, Higher, in[3:0]} driven while in a given state
  function automatic logic [5:0] nib_word(state_e st, logic [7:0] smp, logic [7:0] thr);
    logic [5:0] w;
    case (st)
      S_LO:    w = {NSEL_S_LO, smp[3:0]};
      S_HI:    w = {NSEL_S_HI, smp[7:4]};
      T_LO:    w = {NSEL_T_LO, thr[3:0]};
      T_HI:    w = {NSEL_T_HI, thr[7:4]};
      default: w = {NSEL_S_HI, smp[7:4]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/th_flt_seq_if.sv
// Sample and threshold valid/ready channels into the filter sequencer.
interface th_flt_seq_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] t_data;
  logic       t_valid;
  logic       t_ready;

  modport master (output s_data, s_valid, t_data, t_valid, input s_ready, t_ready);
  modport slave  (input s_data, s_valid, t_data, t_valid, output s_ready, t_ready);
endinterface

// File: rtl/th_flt_seq_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted
// last wins. A grant is an acceptance, so it updates the last-grant flop.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic win_i,
  input  logic req_s_i,
  input  logic req_t_i,
  output logic gnt_s_o,
  output logic gnt_t_o
);

  logic last_t_q;

  assign gnt_t_o = win_i & req_t_i & (~req_s_i | ~last_t_q);
  assign gnt_s_o = win_i & req_s_i & ~gnt_t_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         last_t_q <= 1'b0;
    else if (gnt_t_o) last_t_q <= 1'b1;
    else if (gnt_s_o) last_t_q <= 1'b0;
  end

endmodule

// File: rtl/th_flt_seq.sv
// Serializes 8-bit samples / thresholds into two nibble writes to the
// threshold filter; between transfers it re-presents the held sample.
module th_flt_seq
  import th_flt_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  th_flt_seq_if.slave      bus,
  output logic [3:0]       flt_in,
  output logic             flt_threshold,
  output logic             flt_higher,
  output logic             busy,
  output logic [CNT_W-1:0] smp_cnt
);

  state_e           state_q, state_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [7:0]       thr_q, thr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       flt_q;
  logic             busy_q;
  logic             win, gnt_s, gnt_t;

  // The low-nibble cycles are the only ones that cannot take a new transfer
  assign win = (state_q == IDLE) || (state_q == S_HI) || (state_q == T_HI);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .win_i   (win),
    .req_s_i (bus.s_valid),
    .req_t_i (bus.t_valid),
    .gnt_s_o (gnt_s),
    .gnt_t_o (gnt_t)
  );

  assign bus.s_ready = gnt_s;
  assign bus.t_ready = gnt_t;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    thr_d    = thr_q;
    cnt_d    = cnt_q;
    if (gnt_s) begin
      state_d  = S_LO;
      shadow_d = bus.s_data;
      cnt_d    = cnt_q + 1'b1;
    end else if (gnt_t) begin
      state_d = T_LO;
      thr_d   = bus.t_data;
    end else begin
      case (state_q)
        S_LO:    state_d = S_HI;
        T_LO:    state_d = T_HI;
        default: state_d = IDLE;
      endcase
    end
  end

  // Filter lines are flopped from next state so nothing combinational
  // from valid/data reaches the filter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shadow_q <= 8'h00;
      thr_q    <= 8'h00;
      cnt_q    <= '0;
      flt_q    <= {NSEL_S_HI, 4'h0};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      thr_q    <= thr_d;
      cnt_q    <= cnt_d;
      flt_q    <= nib_word(state_d, shadow_d, thr_d);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign flt_threshold = flt_q[5];
  assign flt_higher    = flt_q[4];
  assign flt_in        = flt_q[3:0];
  assign busy          = busy_q;
  assign smp_cnt       = cnt_q;

endmodule

// File: tb/tb_th_flt_seq.sv
// Randomized bench for th_flt_seq: a transfer-level model predicts grants
// and queues expected transfers; a monitor rebuilds them from the nibble lines.
module tb_th_flt_seq;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       flt_in;
  logic             flt_threshold;
  logic             flt_higher;
  logic             busy;
  logic [CNT_W-1:0] smp_cnt;

  th_flt_seq_if bus ();

  th_flt_seq #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .flt_in        (flt_in),
    .flt_threshold (flt_threshold),
    .flt_higher    (flt_higher),
    .busy          (busy),
    .smp_cnt       (smp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model state: pos 0 = idle, 1 = first beat of a transfer, 2 = second beat
  int   pos;
  logic last_t_m;
  int   cnt_m;
  logic [8:0] exp_q[$];

  // monitor state
  logic       mon_en;
  logic       hi_pending;
  logic       lo_t;
  logic [3:0] lo_nib;
  logic [7:0] last_smp;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pos      = 0;
    last_t_m = 1'b0;
    cnt_m    = 0;
    exp_q.delete();
  endtask

  // One cycle of stimulus; readies, busy and counter are checked against the model.
  task automatic cyc(input logic sv, input logic [7:0] sd, input logic tv, input logic [7:0] td);
    logic es, et;
    @(negedge clk);
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.t_valid = tv;
    bus.t_data  = td;
    #1;
    es = 1'b0;
    et = 1'b0;
    if (pos != 1) begin
      if (sv && tv) begin
        et = ~last_t_m;
        es = last_t_m;
      end else begin
        et = tv;
        es = sv;
      end
    end
    chk("s_ready", bus.s_ready, es);
    chk("t_ready", bus.t_ready, et);
    chk("busy", busy, (pos != 0));
    chk("smp_cnt", smp_cnt, cnt_m % (1 << CNT_W));
    if (es) begin
      exp_q.push_back({1'b0, sd});
      cnt_m++;
      last_t_m = 1'b0;
      pos = 1;
    end else if (et) begin
      exp_q.push_back({1'b1, td});
      last_t_m = 1'b1;
      pos = 1;
    end else if (pos == 1) begin
      pos = 2;
    end else begin
      pos = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Monitor: a Higher=0 beat opens a transfer, the next beat must close it.
  always @(negedge clk) begin
    logic [8:0] e;
    #2;
    if (mon_en && rst) begin
      if (hi_pending) begin
        hi_pending = 1'b0;
        if (flt_higher !== 1'b1 || flt_threshold !== lo_t) begin
          tests++;
          fails++;
          $display("FAIL hi_beat: got thr=%0b hi=%0b, expected thr=%0b hi=1", flt_threshold, flt_higher, lo_t);
        end else if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL xfer: got unexpected transfer t=%0b data=0x%0h", lo_t, {flt_in, lo_nib});
        end else begin
          e = exp_q.pop_front();
          chk("xfer", {lo_t, flt_in, lo_nib}, e);
          if (!e[8]) last_smp = e[7:0];
        end
      end else if (flt_higher === 1'b0) begin
        hi_pending = 1'b1;
        lo_t       = flt_threshold;
        lo_nib     = flt_in;
      end else begin
        chk("idle_word", {flt_threshold, flt_higher, flt_in}, {2'b01, last_smp[7:4]});
      end
    end
  end

  initial begin
    mon_en      = 1'b0;
    hi_pending  = 1'b0;
    last_smp    = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.t_valid = 1'b0;
    bus.t_data  = 8'h00;
    model_reset();
    rst = 1'b0;
    #12;
    chk("rst_flt", {flt_threshold, flt_higher, flt_in}, 6'b01_0000);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", smp_cnt, 0);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;

    // first sample, then threshold updates with samples on either side of it
    cyc(1'b1, 8'hA5, 1'b0, 8'h00);
    idle(3);
    chk("cnt_after_a5", smp_cnt, 1);
    cyc(1'b0, 8'h00, 1'b1, 8'h80);
    idle(2);
    cyc(1'b1, 8'h7F, 1'b0, 8'h00);
    idle(2);
    cyc(1'b1, 8'h90, 1'b0, 8'h00);
    idle(1);
    cyc(1'b0, 8'h00, 1'b1, 8'hA0);
    idle(3);

    // both channels held valid: back-to-back alternating transfers
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 8'($urandom_range(0, 255)), 1'b1, 8'($urandom_range(0, 255)));
    idle(3);

    // reset while the low nibble of a sample is on the port
    cyc(1'b1, 8'h3C, 1'b0, 8'h00);
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("midrst_flt", {flt_threshold, flt_higher, flt_in}, 6'b01_0000);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", smp_cnt, 0);
    model_reset();
    hi_pending = 1'b0;
    last_smp   = 8'h00;
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // random traffic, long enough for the counter to wrap several times
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 99) < 35), 8'($urandom_range(0, 255)));
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
